// File: rtl/sad_pkg.sv
// Shared definitions for the minimum-SAD tracker: state encoding and data defaults.
package sad_pkg;

    localparam int unsigned SAD_DATA_W = 32;
    localparam logic [31:0] SAD_INIT_MIN = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sad_min_compare.sv
// Candidate-vs-best comparator; the tie policy lives only here.
// SAD_TIE_LAST_EN: when defined, equal candidates also update (last equal wins).
module sad_min_compare
    import sad_pkg::*;
#(
    parameter int unsigned DATA_W = SAD_DATA_W
) (
    input  logic [DATA_W-1:0] cand_i,
    input  logic [DATA_W-1:0] best_i,
    output logic              update_c_o
);

`ifdef SAD_TIE_LAST_EN
    assign update_c_o = (cand_i <= best_i);
`else
    assign update_c_o = (cand_i < best_i);
`endif

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the running minimum SAD and its index over one search and feeds the downstream min register.
// Tie policy selected by SAD_TIE_LAST_EN (see sad_min_compare).
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int unsigned       DATA_W   = SAD_DATA_W,
    parameter int unsigned       NUM_CAND = 64,
    parameter int unsigned       IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1,
    parameter logic [DATA_W-1:0] INIT_MIN = DATA_W'(SAD_INIT_MIN)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] CandData,
    input  logic              CandValid,
    output logic              CandReady,
    output logic [DATA_W-1:0] MinData,
    output logic              MinWriteEnable,
    output logic [IDX_W-1:0]  BestIndex,
    output logic              Busy,
    output logic              Done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [DATA_W-1:0] min_data_q, min_data_d;
    logic              min_we_q, min_we_d;
    logic              update_c;
    logic              xfer_c;

    sad_min_compare #(.DATA_W(DATA_W)) u_cmp (
        .cand_i     (CandData),
        .best_i     (best_q),
        .update_c_o (update_c)
    );

    assign xfer_c = CandValid && (state_q == ST_SCAN);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            best_q     <= INIT_MIN;
            best_idx_q <= '0;
            min_data_q <= INIT_MIN;
            min_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            min_data_q <= min_data_d;
            min_we_q   <= min_we_d;
        end
    end

    // Next state: preload on Start, write on improvement, count holds on the last transfer.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        min_data_d = min_data_q;
        min_we_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d    = ST_SCAN;
                    count_d    = '0;
                    best_d     = INIT_MIN;
                    best_idx_d = '0;
                    min_data_d = INIT_MIN;
                    min_we_d   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (xfer_c) begin
                    if (update_c) begin
                        best_d     = CandData;
                        best_idx_d = count_q;
                        min_data_d = CandData;
                        min_we_d   = 1'b1;
                    end
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign CandReady      = (state_q == ST_SCAN);
    assign Busy           = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign Done           = (state_q == ST_DONE);
    assign MinData        = min_data_q;
    assign MinWriteEnable = min_we_q;
    assign BestIndex      = best_idx_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker with NUM_CAND=4; expected writes come from a reference model.
module tb_sad_min_tracker;

    localparam int unsigned N = 4;
`ifdef SAD_TIE_LAST_EN
    localparam bit TIE = 1'b1;
`else
    localparam bit TIE = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [31:0] CandData;
    logic        CandValid;
    logic        CandReady;
    logic [31:0] MinData;
    logic        MinWriteEnable;
    logic [1:0]  BestIndex;
    logic        Busy;
    logic        Done;

    sad_min_tracker #(.NUM_CAND(N)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .CandData       (CandData),
        .CandValid      (CandValid),
        .CandReady      (CandReady),
        .MinData        (MinData),
        .MinWriteEnable (MinWriteEnable),
        .BestIndex      (BestIndex),
        .Busy           (Busy),
        .Done           (Done)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          failures = 0;
    int          we_count = 0;
    int          done_count = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] cand_a[N];
    int          gap_a[N];
    int          exp_idx;
    int          ready_bad;
    int          run_cycles;

    // Scoreboard: every write strobe must match the next modelled write.
    always @(negedge Clk) begin
        if (Done) done_count++;
        if (MinWriteEnable) begin
            we_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected MinData=%h expected no write", MinData);
            end else begin
                mon_exp = exp_q.pop_front();
                if (MinData !== mon_exp) begin
                    failures++;
                    $display("FAIL write_data got=%h expected=%h", MinData, mon_exp);
                end
            end
        end
    end

    task automatic model_search();
        logic [31:0] best;
        best    = 32'hFFFF_FFFF;
        exp_idx = 0;
        exp_q.push_back(best);
        for (int i = 0; i < int'(N); i++) begin
            if (cand_a[i] < best || (TIE && cand_a[i] == best)) begin
                best    = cand_a[i];
                exp_idx = i;
                exp_q.push_back(cand_a[i]);
            end
        end
    endtask

    // Drives one full search; returns #1 after the edge that consumed the last candidate.
    task automatic run_search(input bit hold_start);
        model_search();
        ready_bad  = 0;
        run_cycles = 0;
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = hold_start;
        for (int i = 0; i < int'(N); i++) begin
            for (int g = 0; g < gap_a[i]; g++) begin
                CandValid = 1'b0;
                CandData  = 32'hDEAD_BEEF;
                if (CandReady !== 1'b1) ready_bad++;
                @(posedge Clk); #1;
                run_cycles++;
            end
            CandValid = 1'b1;
            CandData  = cand_a[i];
            if (i == int'(N) - 1) Start = 1'b0;
            if (CandReady !== 1'b1) ready_bad++;
            @(posedge Clk); #1;
            run_cycles++;
        end
        CandValid = 1'b0;
    endtask

    task automatic check_finish(input string name, input int we_before, input int done_before);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_done Done=%b Busy=%b expected 1/1", name, Done, Busy);
        end
        checks++;
        if (BestIndex !== 2'(exp_idx)) begin
            failures++;
            $display("FAIL %s_index got=%0d expected=%0d", name, BestIndex, exp_idx);
        end
        @(posedge Clk); #1;
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || CandReady !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle Done=%b Busy=%b CandReady=%b expected 0/0/0", name, Done, Busy, CandReady);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (done_count - done_before != 1) begin
            failures++;
            $display("FAIL %s_done_pulses got=%0d expected 1", name, done_count - done_before);
        end
        @(posedge Clk); #1;
        checks++;
        if (BestIndex !== 2'(exp_idx)) begin
            failures++;
            $display("FAIL %s_index_hold got=%0d expected=%0d", name, BestIndex, exp_idx);
        end
        if (we_before < 0) $display("bad arg");
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; CandValid = 1'b0; CandData = '0;
        #12;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (MinData !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_mindata got=%h expected=ffffffff", MinData);
        end
        checks++;
        if ({MinWriteEnable, Done, Busy, CandReady} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes we/done/busy/ready=%b expected 0000", {MinWriteEnable, Done, Busy, CandReady});
        end
        checks++;
        if (BestIndex !== 2'd0) begin
            failures++;
            $display("FAIL reset_index got=%0d expected 0", BestIndex);
        end
    endtask

    task automatic test_back_to_back();
        int we0, d0;
        cand_a = '{32'd50, 32'd30, 32'd40, 32'd10};
        gap_a  = '{0, 0, 0, 0};
        we0 = we_count; d0 = done_count;
        run_search(1'b0);
        check_finish("b2b", we0, d0);
        checks++;
        if (we_count - we0 != 4) begin
            failures++;
            $display("FAIL b2b_write_count got=%0d expected 4", we_count - we0);
        end
    endtask

    task automatic test_ties();
        int we0, d0;
        cand_a = '{32'd20, 32'd20, 32'd25, 32'd20};
        gap_a  = '{0, 0, 0, 0};
        we0 = we_count; d0 = done_count;
        run_search(1'b0);
        check_finish("ties", we0, d0);
        checks++;
        if (we_count - we0 != (TIE ? 4 : 2)) begin
            failures++;
            $display("FAIL ties_write_count got=%0d expected %0d", we_count - we0, TIE ? 4 : 2);
        end
    endtask

    task automatic test_no_improve();
        int we0, d0;
        cand_a = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        gap_a  = '{0, 0, 0, 0};
        we0 = we_count; d0 = done_count;
        run_search(1'b0);
        check_finish("noimp", we0, d0);
    endtask

    task automatic test_stall();
        int we0, d0;
        cand_a = '{32'd50, 32'd30, 32'd40, 32'd10};
        gap_a  = '{0, 2, 2, 2};
        we0 = we_count; d0 = done_count;
        run_search(1'b0);
        checks++;
        if (ready_bad != 0 || run_cycles != 10) begin
            failures++;
            $display("FAIL stall_ready ready_drops=%0d cycles=%0d expected 0/10", ready_bad, run_cycles);
        end
        check_finish("stall", we0, d0);
        checks++;
        if (we_count - we0 != 4) begin
            failures++;
            $display("FAIL stall_write_count got=%0d expected 4", we_count - we0);
        end
    endtask

    task automatic test_start_in_scan();
        int we0, d0;
        cand_a = '{32'd9, 32'd7, 32'd8, 32'd3};
        gap_a  = '{1, 0, 1, 0};
        we0 = we_count; d0 = done_count;
        run_search(1'b1);
        check_finish("restart", we0, d0);
        checks++;
        if (we_count - we0 != 4) begin
            failures++;
            $display("FAIL restart_write_count got=%0d expected 4", we_count - we0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_count;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'd50);
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        CandValid = 1'b1; CandData = 32'd50;
        @(posedge Clk); #1;
        CandData = 32'd30;
        @(posedge Clk); #1;
        CandValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (MinData !== 32'hFFFF_FFFF || {MinWriteEnable, Busy, Done, CandReady} !== 4'b0000 || BestIndex !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_clear MinData=%h we/busy/done/ready=%b idx=%0d expected ffffffff/0000/0",
                     MinData, {MinWriteEnable, Busy, Done, CandReady}, BestIndex);
        end
        repeat (3) @(posedge Clk);
        #3;
        Reset = 1'b0;
        exp_q.delete();
        repeat (6) @(posedge Clk);
        #1;
        checks++;
        if (done_count != d0) begin
            failures++;
            $display("FAIL reset_mid_no_done pulses=%0d expected 0", done_count - d0);
        end
        test_back_to_back();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ties();
        test_no_improve();
        test_stall();
        test_start_in_scan();
        test_reset_mid();
        repeat (3) @(posedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout simulation exceeded 50000 time units");
        $fatal(1);
    end

endmodule
